// File: rtl/nes_pad_multiport_ctrl.sv
// nes_pad_multiport_ctrl: one or two NES pad shift registers behind $4016/$4017
//   clk, rst            : clock, async active-high reset
//   cpu_addr/cpu_data   : CPU bus address and write data (bit 0 = strobe)
//   cpu_write_en/read_en: CPU access qualifiers (reads may span several cycles)
//   pad_buttons         : raw button levels, port p at [p*PAD_BITS +: PAD_BITS]
//   cpu_rd_data/rd_hit  : registered serial bit and its one-cycle valid pulse
//   pad_strobe          : current strobe level
module nes_pad_multiport_ctrl #(
  parameter logic [15:0] BASE_ADDR = 16'h4016,
  parameter int NUM_PORTS = 2,
  parameter int PAD_BITS = 8,
  parameter logic FILL_BIT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0] cpu_data,
  input  logic cpu_write_en,
  input  logic cpu_read_en,
  input  logic [NUM_PORTS*PAD_BITS-1:0] pad_buttons,
  output logic [7:0] cpu_rd_data,
  output logic cpu_rd_hit,
  output logic pad_strobe
);
  logic [NUM_PORTS*PAD_BITS-1:0] btn_meta, sync_btn;
  logic [PAD_BITS-1:0] shreg [NUM_PORTS];
  logic [NUM_PORTS-1:0] hit, hit_prev, qual;
  logic strobe, rd_bit, unused_data;
  assign pad_strobe = strobe;
  assign unused_data = ^cpu_data[7:1];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      btn_meta <= '0;
      sync_btn <= '0;
      strobe <= 1'b0;
      hit_prev <= '0;
    end else begin
      btn_meta <= pad_buttons;
      sync_btn <= btn_meta;
      hit_prev <= hit;
      if (cpu_write_en && cpu_addr == BASE_ADDR) strobe <= cpu_data[0];
    end
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign hit[p] = cpu_read_en && cpu_addr == BASE_ADDR + 16'(p);
    // any write in the same cycle wins over the read
    assign qual[p] = hit[p] && !hit_prev[p] && !cpu_write_en;
    always_ff @(posedge clk or posedge rst)
      if (rst) shreg[p] <= {PAD_BITS{FILL_BIT}};
      else if (strobe) shreg[p] <= sync_btn[p*PAD_BITS +: PAD_BITS];
      else if (qual[p]) shreg[p] <= (shreg[p] >> 1) | (PAD_BITS'(FILL_BIT) << (PAD_BITS - 1));
  end
  always_comb begin
    rd_bit = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (qual[i]) rd_bit = strobe ? sync_btn[i*PAD_BITS] : shreg[i][0];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cpu_rd_data <= 8'h00;
      cpu_rd_hit <= 1'b0;
    end else begin
      cpu_rd_hit <= |qual;
      if (|qual) cpu_rd_data <= {7'b0, rd_bit};
    end
endmodule

// File: doc/nes_pad_multiport_ctrl.md
# nes_pad_multiport_ctrl

Parametrised NES controller-port block that emulates one or two standard pad shift registers behind the CPU's memory-mapped `$4016`/`$4017` registers. It sits on the CPU bus beside the memory controller. It captures live button states while strobe is held, then serially returns one bit per CPU read, with a programmable fill value after the pad bits are exhausted. Compared with the single-port controller, it adds:
- level-sensitive strobe,
- a port count parameter,
- a pad width parameter,
- input synchronisation,
- once-per-access read qualification,
- an address-hit indication.

## Interface
Parameters:
- `BASE_ADDR`, 16'h4016, address of port 0; port p is at `BASE_ADDR + p`; strobe register is `BASE_ADDR` only.
- `NUM_PORTS`, 2, number of pad ports; legal values are 1 or 2.
- `PAD_BITS`, 8, buttons per pad; legal range is 1..16; bit 0 is shifted out first.
- `FILL_BIT`, 1'b1, value shifted in behind the pad bits and returned after `PAD_BITS` reads.

Ports:
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_addr`  in  16  CPU address.
- `cpu_data`  in  8  CPU write data; only bit 0 is used.
- `cpu_write_en`  in  1  CPU write qualifier.
- `cpu_read_en`  in  1  CPU read qualifier; may be held for several cycles per access.
- `pad_buttons`  in  `NUM_PORTS*PAD_BITS`  asynchronous button levels, 1 = pressed; port p occupies `[p*PAD_BITS +: PAD_BITS]`.
- `cpu_rd_data`  out  8  registered read value `{7'b0, serial_bit}`.
- `cpu_rd_hit`  out  1  registered; 1 on the cycle `cpu_rd_data` is updated by a qualified read.
- `pad_strobe`  out  1  current strobe level, for external pad hardware.

## Operation
- **Synchroniser:** `pad_buttons` passes through a 2-flop synchroniser; the result is called `sync_btn`. All capture uses `sync_btn`.
- **Strobe register:**
  - A write to `BASE_ADDR` sets `strobe <= cpu_data[0]`.
  - Writes to `BASE_ADDR+1` are ignored; that address belongs to the APU frame counter on writes.
- **Strobe high:** every cycle, each port's shift register loads `sync_btn` for that port.
  - Reads return `sync_btn[port][0]` live and do not shift.
- **Strobe low:** the shift registers hold their last loaded value. A write that drops strobe does not itself reload.
- **Read qualification:**
  - `hit_p` = `cpu_read_en && cpu_addr == BASE_ADDR+p`, for p < `NUM_PORTS`.
  - A per-port `hit_prev_p` flop records the previous cycle's `hit_p`.
  - A qualified read is `hit_p && !hit_prev_p`. Multi-cycle reads therefore count once.
- **Qualified read, strobe low:**
  - `cpu_rd_data <= {7'b0, shreg_p[0]}`.
  - `shreg_p <= {FILL_BIT, shreg_p[PAD_BITS-1:1]}`.
- **Qualified read, strobe high:** `cpu_rd_data <= {7'b0, sync_btn_p[0]}`, with no shift.
- **Read of a port address ≥ `NUM_PORTS`:** no hit, `cpu_rd_data` unchanged, `cpu_rd_hit` = 0.
- **Port independence:** each port has its own shift register and `hit_prev`. Reading port 0 never shifts port 1.
- **Overread:** after `PAD_BITS` qualified reads, every further read returns `FILL_BIT` indefinitely. There is no wrap-around.
- **Simultaneous write and read in the same cycle:** the write takes priority. Strobe updates and the read is ignored: no shift, no `cpu_rd_hit`. `hit_prev` still updates.

## Timing
- **Reset values:**
  - `cpu_rd_data` = 8'h00, `cpu_rd_hit` = 0, `pad_strobe` = 0.
  - Every shift register holds all `FILL_BIT`.
  - Synchroniser flops and `hit_prev` = 0.
- **Reset mid-read or mid-strobe:** all state returns immediately to the reset values. No capture happens until the next strobe.
- **Input latency:** a `pad_buttons` change is visible in `sync_btn` 2 rising edges later. With strobe high, it is in `shreg` 3 edges later.
- **Strobe latency:** `pad_strobe` changes at the edge that samples the write.
- **Read latency:** `cpu_rd_data` and `cpu_rd_hit` update at the edge that samples the first cycle of a qualified read. The value is valid the following cycle.
  - `cpu_rd_hit` is a 1-cycle pulse.
  - `cpu_rd_data` holds until the next qualified read or reset.
- **Read/write spacing:** back-to-back reads separated by at least one non-hit cycle each shift once. A read held N cycles shifts once.
- **Capture point:** the first read after a write of 0 returns the bit captured on the last strobe-high cycle, i.e. the cycle before strobe cleared.

## Test plan
- **Reset:** assert `rst` with `pad_buttons` = 16'hFFFF -> `cpu_rd_data` = 00, `cpu_rd_hit` = 0, `pad_strobe` = 0. A read of `$4016` before any strobe returns 01.
- **Basic serial read:**
  - Stimulus: port 0 buttons = 8'hA5; write `$4016` = 01, wait 4 cycles, write 00; then 10 single-cycle reads of `$4016`.
  - Required: bit0 = 1,0,1,0,0,1,0,1,1,1.
- **Strobe held:** strobe = 1 with port 0 buttons = 8'h01, then 8'h00. Reads return 01 then 00 (after 2-cycle sync) and never shift. After strobe clears, the first read returns 00.
- **Multi-cycle read and port independence:**
  - Stimulus: port 0 = 8'h02, port 1 = 8'hFE, captured. Read `$4016` held 5 cycles, then a second read; interleave `$4017` reads.
  - Required: `$4016` returns 00 then 01, with one `cpu_rd_hit` pulse per access. `$4017` returns 00 then 01, unaffected by `$4016` reads.
- **Port count and write conflict:**
  - With `NUM_PORTS` = 1, a read of `$4017` -> no `cpu_rd_hit`, data unchanged.
  - Write and read of `$4016` in the same cycle -> strobe updates, no shift, no hit.
- **Reset mid-operation:** assert `rst` after 3 of 8 reads -> all outputs return to reset values. The next read returns `FILL_BIT` until a new strobe.
